fft8_bfly_sched: RTL and testbench

Iterative scheduler that computes an 8-point radix-2 DIT FFT on one shared butterfly unit instead of twelve instantiated ones.
- Accepts 8 complex samples on a valid/ready stream and stores them bit-reversed in an internal 8-entry bank.
- Issues the 12 butterflies (3 stages x 4) to the external butterfly, writes results back in place, then streams out 8 results.
- Sits between the sample source and the shared butterfly2p-style datapath.

---
 rtl/fft8_bfly_sched_if.sv | 32 +++
 rtl/fft8_bfly_sched.sv | 157 +++++++++++++++
 tb/tb_fft8_bfly_sched.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft8_bfly_sched_if.sv
// Stream, butterfly and status bundle of the 8-point FFT scheduler.
// The slave view belongs to the scheduler and the master view to its environment.
interface fft8_bfly_sched_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] bf_a;
    logic [DATA_W-1:0] bf_b;
    logic [2:0]        bf_tw;
    logic              bf_valid;
    logic [DATA_W-1:0] bf_res1;
    logic [DATA_W-1:0] bf_res2;
    logic              bf_res_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              err;

    modport slave (
        input  in_data, in_valid, bf_res1, bf_res2, bf_res_valid, out_ready,
        output in_ready, bf_a, bf_b, bf_tw, bf_valid, out_data, out_valid, out_last, busy, err
    );

    modport master (
        output in_data, in_valid, bf_res1, bf_res2, bf_res_valid, out_ready,
        input  in_ready, bf_a, bf_b, bf_tw, bf_valid, out_data, out_valid, out_last, busy, err
    );
endinterface

// File: rtl/fft8_bfly_sched.sv
// 8-point radix-2 DIT FFT sequenced over one external butterfly unit.
// Samples land bit-reversed in an 8-entry bank; 3 stages x 4 butterflies run in place.
module fft8_bfly_sched #(
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    fft8_bfly_sched_if.slave bus
);
    typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_OUT} state_t;

    typedef struct packed {
        logic [2:0] up;
        logic [2:0] lo;
        logic [2:0] tw;
    } pair_t;

    // Butterfly j of stage s: upper/lower bank index and twiddle exponent.
    function automatic pair_t pair_sel(input logic [1:0] s, input logic [1:0] j);
        pair_t p;
        case (s)
            2'd1: begin
                p.up = {j[1], 1'b0, j[0]};
                p.lo = {j[1], 1'b1, j[0]};
                p.tw = {1'b0, j[0], 1'b0};
            end
            2'd2: begin
                p.up = {1'b0, j};
                p.lo = {1'b1, j};
                p.tw = {1'b0, j};
            end
            default: begin
                p.up = {j, 1'b0};
                p.lo = {j, 1'b1};
                p.tw = 3'd0;
            end
        endcase
        return p;
    endfunction

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_bank [8];
    logic [2:0]        r_n;
    logic [2:0]        r_m;
    logic [1:0]        r_k;
    logic [1:0]        r_r;
    logic [1:0]        r_s;
    logic              r_busy;
    logic              r_err;

    pair_t w_iss;
    pair_t w_ret;
    logic  w_in_fire;
    logic  w_out_fire;
    logic  w_res_ok;
    logic  w_res_last;
    logic  w_res_err;

    assign w_iss      = pair_sel(r_s, r_k);
    assign w_ret      = pair_sel(r_s, r_r);
    assign w_in_fire  = (r_state == S_LOAD) && bus.in_valid;
    assign w_out_fire = (r_state == S_OUT) && bus.out_ready;

    // A result is only legal for a butterfly already issued in this stage:
    // r_k butterflies precede the current ISSUE cycle, all four precede WAIT.
    assign w_res_ok   = bus.bf_res_valid &&
                        (((r_state == S_ISSUE) && (r_r < r_k)) || (r_state == S_WAIT));
    assign w_res_last = w_res_ok && (r_r == 2'd3);
    assign w_res_err  = bus.bf_res_valid && !w_res_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // The 4th result of a stage releases the barrier in the cycle it is written,
    // so the next stage's first operands read the already-updated bank.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (w_in_fire && (r_n == 3'd7)) w_next = S_ISSUE;
            S_ISSUE: if (r_k == 2'd3) w_next = S_WAIT;
            S_WAIT:  if (w_res_last) w_next = (r_s == 2'd2) ? S_OUT : S_ISSUE;
            S_OUT:   if (w_out_fire && (r_m == 3'd7)) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.bf_valid  = 1'b0;
        bus.bf_a      = '0;
        bus.bf_b      = '0;
        bus.bf_tw     = 3'd0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        case (r_state)
            S_LOAD: bus.in_ready = 1'b1;
            S_ISSUE: begin
                bus.bf_valid = 1'b1;
                bus.bf_a     = r_bank[w_iss.up];
                bus.bf_b     = r_bank[w_iss.lo];
                bus.bf_tw    = w_iss.tw;
            end
            S_OUT: begin
                bus.out_valid = 1'b1;
                bus.out_data  = r_bank[r_m];
                bus.out_last  = (r_m == 3'd7);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n    <= 3'd0;
            r_m    <= 3'd0;
            r_k    <= 2'd0;
            r_r    <= 2'd0;
            r_s    <= 2'd0;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_in_fire) r_n <= r_n + 3'd1;
            if (r_state == S_ISSUE) r_k <= r_k + 2'd1;
            if (w_res_ok) r_r <= r_r + 2'd1;
            if (w_res_last) r_s <= (r_s == 2'd2) ? 2'd0 : r_s + 2'd1;
            if (w_out_fire) r_m <= r_m + 3'd1;
            if (w_in_fire && (r_n == 3'd0)) begin
                r_busy <= 1'b1;
            end else if (w_out_fire && (r_m == 3'd7)) begin
                r_busy <= 1'b0;
            end
            if (w_res_err) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) r_bank[bitrev3(r_n)] <= bus.in_data;
        if (w_res_ok) begin
            r_bank[w_ret.up] <= bus.bf_res1;
            r_bank[w_ret.lo] <= bus.bf_res2;
        end
    end

    assign bus.busy = r_busy;
    assign bus.err  = r_err;
endmodule

// File: tb/tb_fft8_bfly_sched.sv
// Directed bench for fft8_bfly_sched with a fixed-point butterfly model of
// programmable latency; expected FFT bins are hand-computed constants.
module tb_fft8_bfly_sched;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft8_bfly_sched_if #(.DATA_W(DATA_W)) bus ();
    fft8_bfly_sched #(.DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    bit spur = 1'b0;
    int n_iss = 0;
    int n_res = 0;
    logic [31:0] iss_a [16];
    logic [31:0] iss_b [16];
    logic [2:0]  iss_tw [16];
    int          iss_cyc [16];
    int          res_cyc [16];

    logic        pv [8];
    logic [31:0] p1 [8];
    logic [31:0] p2 [8];

    logic [31:0] x_imp [8] = '{0: 32'h0100_0000, default: 32'h0};
    logic [31:0] x_one [8] = '{default: 32'h0100_0000};
    logic [31:0] x_jn  [8] = '{32'h0100_0000, 32'h0000_0100, 32'hFF00_0000, 32'h0000_FF00,
                               32'h0100_0000, 32'h0000_0100, 32'hFF00_0000, 32'h0000_FF00};
    logic [31:0] x_ramp [8];
    logic [31:0] e_imp [8] = '{default: 32'h0100_0000};
    logic [31:0] e_one [8] = '{0: 32'h0800_0000, default: 32'h0};
    logic [31:0] e_jn  [8] = '{2: 32'h0800_0000, default: 32'h0};
    logic [31:0] e_ramp [8] = '{0: 32'h2400_0000, 4: 32'hFC00_0000, default: 32'h0};
    int tw_exp [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int up_exp [4] = '{0, 2, 1, 3};
    int lo_exp [4] = '{4, 6, 5, 7};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] twmul(input logic [31:0] b, input logic [2:0] k);
        int r;
        int i;
        logic [15:0] o_r;
        logic [15:0] o_i;
        r = int'($signed(b[31:16]));
        i = int'($signed(b[15:0]));
        case (k)
            3'd1: begin
                o_r = 16'(((r + i) * 23170) >>> 15);
                o_i = 16'(((i - r) * 23170) >>> 15);
            end
            3'd2: begin
                o_r = 16'(i);
                o_i = 16'(-r);
            end
            3'd3: begin
                o_r = 16'(((i - r) * 23170) >>> 15);
                o_i = 16'(((-r - i) * 23170) >>> 15);
            end
            default: begin
                o_r = 16'(r);
                o_i = 16'(i);
            end
        endcase
        return {o_r, o_i};
    endfunction

    function automatic logic [31:0] cadd(input logic [31:0] a, input logic [31:0] w, input bit neg);
        logic [15:0] re;
        logic [15:0] im;
        re = neg ? a[31:16] - w[31:16] : a[31:16] + w[31:16];
        im = neg ? a[15:0] - w[15:0] : a[15:0] + w[15:0];
        return {re, im};
    endfunction

    // External butterfly: captures an issue on one falling edge, returns it lat cycles later.
    initial begin
        logic [31:0] w;
        bus.bf_res_valid = 1'b0;
        bus.bf_res1 = '0;
        bus.bf_res2 = '0;
        for (int i = 0; i < 8; i++) begin
            pv[i] = 1'b0;
            p1[i] = '0;
            p2[i] = '0;
        end
        forever begin
            @(negedge clk);
            bus.bf_res_valid = pv[lat-1];
            bus.bf_res1 = p1[lat-1];
            bus.bf_res2 = p2[lat-1];
            if (pv[lat-1]) begin
                if (n_res < 16) res_cyc[n_res] = cyc;
                n_res++;
            end
            if (spur) begin
                bus.bf_res_valid = 1'b1;
                bus.bf_res1 = 32'h1234_5678;
                bus.bf_res2 = 32'h9ABC_DEF0;
                spur = 1'b0;
            end
            for (int i = 7; i > 0; i--) begin
                pv[i] = (i < lat) ? pv[i-1] : 1'b0;
                p1[i] = p1[i-1];
                p2[i] = p2[i-1];
            end
            w = twmul(bus.bf_b, bus.bf_tw);
            pv[0] = bus.bf_valid;
            p1[0] = cadd(bus.bf_a, w, 1'b0);
            p2[0] = cadd(bus.bf_a, w, 1'b1);
            if (bus.bf_valid) begin
                if (n_iss < 16) begin
                    iss_a[n_iss] = bus.bf_a;
                    iss_b[n_iss] = bus.bf_b;
                    iss_tw[n_iss] = bus.bf_tw;
                    iss_cyc[n_iss] = cyc;
                end
                n_iss++;
            end
        end
    end

    task automatic load_frame(input logic [31:0] x [8], input int gap_at);
        int n = 0;
        int t = 0;
        int g = 0;
        logic rdy;
        while (n < 8 && t < 200) begin
            rdy = 1'b0;
            if (n == gap_at && g < 3) begin
                bus.in_valid = 1'b0;
                g++;
                if (g == 3) begin
                    chk("gap_rdy", bus.in_ready, 1);
                    chk("gap_busy", bus.busy, 1);
                end
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data = x[n];
                rdy = bus.in_ready;
            end
            @(negedge clk);
            t++;
            if (bus.in_valid && rdy) n++;
        end
        bus.in_valid = 1'b0;
        chk("load_n", n, 8);
        chk("busy_run", bus.busy, 1);
        chk("rdy_run", bus.in_ready, 0);
    endtask

    task automatic get_frame(input logic [31:0] exp [8], input logic [7:0] mask,
                             input int stall_m, input int stall_n, input bit hold_in);
        int got = 0;
        int t = 0;
        int st = 0;
        int bad = 0;
        if (hold_in) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'hDEAD_BEEF;
        end
        while (got < 8 && t < 400) begin
            bus.out_ready = 1'b1;
            if (bus.out_valid) begin
                if (hold_in && bus.in_ready) bad++;
                if (got == stall_m && st < stall_n) begin
                    bus.out_ready = 1'b0;
                    st++;
                    chk($sformatf("hold%0d", st), bus.out_data, exp[stall_m]);
                end else begin
                    if (mask[got]) chk($sformatf("X%0d", got), bus.out_data, exp[got]);
                    chk($sformatf("last%0d", got), bus.out_last, got == 7);
                    got++;
                end
            end
            @(negedge clk);
            t++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("out_cnt", got, 8);
        if (hold_in) chk("in_rdy_out", bad, 0);
        chk("busy_end", bus.busy, 0);
        chk("rdy_end", bus.in_ready, 1);
        chk("n_iss", n_iss, 12);
    endtask

    task automatic start(input int l);
        lat = l;
        n_iss = 0;
        n_res = 0;
    endtask

    initial begin
        int t;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) x_ramp[n] = {16'((n + 1) * 256), 16'h0};
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_bf_valid", bus.bf_valid, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_bf_a", bus.bf_a, 0);
        chk("rst_bf_b", bus.bf_b, 0);
        chk("rst_bf_tw", bus.bf_tw, 0);
        chk("rst_out_data", bus.out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // impulse, latency 1
        start(1);
        load_frame(x_imp, 8);
        get_frame(e_imp, 8'hFF, 8, 0, 1'b0);
        chk("err_imp", bus.err, 0);

        // all ones with an input gap, twiddle order
        start(1);
        load_frame(x_one, 3);
        get_frame(e_one, 8'hFF, 8, 0, 1'b0);
        for (int i = 0; i < 12; i++) chk($sformatf("tw%0d", i), iss_tw[i], tw_exp[i]);

        // ramp at latency 5: stage-0 operand pairing and the stage barrier
        start(5);
        load_frame(x_ramp, 8);
        get_frame(e_ramp, 8'h11, 8, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s0_a%0d", k), iss_a[k], x_ramp[up_exp[k]]);
            chk($sformatf("s0_b%0d", k), iss_b[k], x_ramp[lo_exp[k]]);
        end
        chk("lat5", res_cyc[0] - iss_cyc[0], 5);
        // a stage occupies 4+L cycles, so the next issue follows the last one by L+1
        chk("gap_iss", iss_cyc[4] - iss_cyc[3], 6);
        chk("gap_res", iss_cyc[4] - res_cyc[3], 1);

        // j^n at latency 2, sink stalls 3 cycles on X2, input pushed during OUT
        start(2);
        load_frame(x_jn, 8);
        get_frame(e_jn, 8'hFF, 2, 3, 1'b1);
        chk("err_clean", bus.err, 0);

        // stray result while idle, then a clean frame
        spur = 1'b1;
        repeat (2) @(negedge clk);
        chk("err_spur", bus.err, 1);
        start(1);
        load_frame(x_one, 8);
        get_frame(e_one, 8'hFF, 8, 0, 1'b0);
        chk("err_sticky", bus.err, 1);

        // reset while stage 1 waits on results, then a fresh impulse
        start(4);
        load_frame(x_one, 8);
        t = 0;
        while (n_iss < 8 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("reach_s1", n_iss >= 8, 1);
        @(negedge clk);
        chk("pre_rst_wait", bus.bf_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_err", bus.err, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_rdy", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("stale_err", bus.err, 1);
        start(4);
        load_frame(x_imp, 8);
        get_frame(e_imp, 8'hFF, 8, 0, 1'b0);
        chk("err_after", bus.err, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
